// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request and response bus between the MEM stage and the data-memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, stall, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, stall, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word memory that stalls the pipeline while a load/store is outstanding.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input logic clk,
    input logic rst,
    data_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, nextState;
    logic [3:0] waitCnt;
    logic latWrite, latMis;
    logic [ADDR_W-1:0] latIdx;
    logic [31:0] latWdata;
    logic [31:0] mem [2**ADDR_W];
    logic accept, curWrite, curMis;
    logic [ADDR_W-1:0] curIdx;
    logic respValid, respErr;
    logic [31:0] respRdata;
    logic unusedAddr;
    assign unusedAddr = ^bus.req_addr[31:ADDR_W+2];
    assign accept = state == IDLE && bus.req_valid;
    // With LATENCY=1 the response is built on the accept edge, before the latches hold the request.
    assign curWrite = accept ? bus.req_write : latWrite;
    assign curMis = accept ? |bus.req_addr[1:0] : latMis;
    assign curIdx = accept ? bus.req_addr[ADDR_W+1:2] : latIdx;
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : nextState;
    end
    always_comb begin
        nextState = state == IDLE ? (accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                    state == WAIT ? (waitCnt == 4'd0 ? RESP : WAIT) : IDLE;
    end
    always_comb begin
        bus.req_ready = state == IDLE;
        bus.stall = bus.req_valid && state != RESP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= 4'd0;
            respValid <= 1'b0;
            respErr <= 1'b0;
            respRdata <= 32'd0;
        end else begin
            if (accept) begin
                latWrite <= bus.req_write;
                latMis <= |bus.req_addr[1:0];
                latIdx <= bus.req_addr[ADDR_W+1:2];
                latWdata <= bus.req_wdata;
            end
            waitCnt <= accept ? 4'(LATENCY - 2) : (state == WAIT ? waitCnt - 4'd1 : waitCnt);
            respValid <= nextState == RESP;
            respErr <= nextState == RESP && curMis;
            if (nextState == RESP)
                respRdata <= (curWrite || curMis) ? 32'd0 : mem[curIdx];
        end
    end
    // Stores commit as RESP is left so a following load sees the new word.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && latWrite && !latMis)
            mem[latIdx] <= latWdata;
    end
    assign bus.resp_valid = respValid;
    assign bus.resp_err = respErr;
    assign bus.resp_rdata = respRdata;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of timing, store/load data, misalignment, aliasing and reset abort.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic reqValid = 1'b0;
    logic reqWrite = 1'b0;
    logic [31:0] reqAddr = 32'd0;
    logic [31:0] reqWdata = 32'd0;
    int checks = 0;
    int errors = 0;
    data_mem_responder_if busA ();
    data_mem_responder_if busB ();
    assign busA.req_valid = reqValid & ~sel;
    assign busB.req_valid = reqValid & sel;
    assign busA.req_write = reqWrite;
    assign busB.req_write = reqWrite;
    assign busA.req_addr = reqAddr;
    assign busB.req_addr = reqAddr;
    assign busA.req_wdata = reqWdata;
    assign busB.req_wdata = reqWdata;
    data_mem_responder #(.ADDR_W(10), .LATENCY(3)) dutA (.clk(clk), .rst(rst), .bus(busA));
    data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dutB (.clk(clk), .rst(rst), .bus(busB));
    logic sStall, sReady, sValid, sErr;
    logic [31:0] sRdata;
    assign sStall = sel ? busB.stall : busA.stall;
    assign sReady = sel ? busB.req_ready : busA.req_ready;
    assign sValid = sel ? busB.resp_valid : busA.resp_valid;
    assign sErr = sel ? busB.resp_err : busA.resp_err;
    assign sRdata = sel ? busB.resp_rdata : busA.resp_rdata;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request from IDLE, waits (bounded) for its response, then releases the bus.
    task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic e, output int stallCnt, output int respCyc);
        reqWrite = w;
        reqAddr = a;
        reqWdata = d;
        reqValid = 1'b1;
        stallCnt = 0;
        respCyc = 0;
        rd = 32'hx;
        e = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (sStall) stallCnt++;
            if (sValid) begin
                respCyc = i;
                rd = sRdata;
                e = sErr;
                break;
            end
            tick();
        end
        tick();
        reqValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (busA.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", busA.resp_valid); end
        checks++; if (busA.resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata got %h want 0", busA.resp_rdata); end
        checks++; if (busA.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", busA.resp_err); end
        checks++; if (busA.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", busA.req_ready); end
        checks++; if (busA.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", busA.stall); end
        checks++; if (busB.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_b_resp_valid got %b want 0", busB.resp_valid); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_store_timing();
        logic [4:0] exStall = 5'b00111;
        logic [4:0] exReady = 5'b10001;
        logic [4:0] exValid = 5'b01000;
        sel = 1'b0;
        reqWrite = 1'b1;
        reqAddr = 32'h10;
        reqWdata = 32'hDEADBEEF;
        reqValid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) reqValid = 1'b0;
            @(negedge clk);
            checks++; if (sStall !== exStall[c-1]) begin errors++; $display("FAIL t1_stall cycle %0d got %b want %b", c, sStall, exStall[c-1]); end
            checks++; if (sReady !== exReady[c-1]) begin errors++; $display("FAIL t1_req_ready cycle %0d got %b want %b", c, sReady, exReady[c-1]); end
            checks++; if (sValid !== exValid[c-1]) begin errors++; $display("FAIL t1_resp_valid cycle %0d got %b want %b", c, sValid, exValid[c-1]); end
            if (c == 4) begin
                checks++; if (sErr !== 1'b0) begin errors++; $display("FAIL t1_resp_err got %b want 0", sErr); end
                checks++; if (sRdata !== 32'd0) begin errors++; $display("FAIL t1_store_rdata got %h want 0", sRdata); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic e;
        int sc, rc;
        sel = 1'b0;
        transact(1'b1, 32'h20, 32'h12345678, rd, e, sc, rc);
        checks++; if (rc !== 4) begin errors++; $display("FAIL t2_store_resp_cycle got %0d want 4", rc); end
        checks++; if (sc !== 3) begin errors++; $display("FAIL t2_store_stall_cycles got %0d want 3", sc); end
        transact(1'b0, 32'h20, 32'h0, rd, e, sc, rc);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL t2_load_rdata got %h want 12345678", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL t2_load_err got %b want 0", e); end
        checks++; if (rc !== 4) begin errors++; $display("FAIL t2_load_resp_cycle got %0d want 4", rc); end
        checks++; if (sc !== 3) begin errors++; $display("FAIL t2_load_stall_cycles got %0d want 3", sc); end
    endtask

    task automatic test_latency_one();
        logic [31:0] rd;
        logic e;
        int sc, rc;
        sel = 1'b1;
        transact(1'b1, 32'h0, 32'hA5A5A5A5, rd, e, sc, rc);
        checks++; if (rc !== 2) begin errors++; $display("FAIL t3_store_resp_cycle got %0d want 2", rc); end
        transact(1'b0, 32'h0, 32'h0, rd, e, sc, rc);
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL t3_load_rdata got %h want a5a5a5a5", rd); end
        checks++; if (rc !== 2) begin errors++; $display("FAIL t3_load_resp_cycle got %0d want 2", rc); end
        checks++; if (sc !== 1) begin errors++; $display("FAIL t3_load_stall_cycles got %0d want 1", sc); end
        sel = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic e;
        int sc, rc;
        sel = 1'b0;
        transact(1'b1, 32'h22, 32'hFFFFFFFF, rd, e, sc, rc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL t4_mis_store_err got %b want 1", e); end
        checks++; if (rc !== 4) begin errors++; $display("FAIL t4_mis_store_resp_cycle got %0d want 4", rc); end
        transact(1'b0, 32'h20, 32'h0, rd, e, sc, rc);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL t4_load_after_mis_store got %h want 12345678", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL t4_aligned_load_err got %b want 0", e); end
        transact(1'b0, 32'h21, 32'h0, rd, e, sc, rc);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL t4_mis_load_rdata got %h want 0", rd); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL t4_mis_load_err got %b want 1", e); end
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        logic e;
        int sc, rc;
        sel = 1'b0;
        transact(1'b1, 32'h1000, 32'h77, rd, e, sc, rc);
        transact(1'b0, 32'h0, 32'h0, rd, e, sc, rc);
        checks++; if (rd !== 32'h77) begin errors++; $display("FAIL t5_alias_rdata got %h want 77", rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic e;
        int sc, rc;
        int badValid = 0;
        int badReady = 0;
        sel = 1'b0;
        transact(1'b1, 32'h40, 32'h11111111, rd, e, sc, rc);
        checks++; if (rc !== 4) begin errors++; $display("FAIL t6_setup_resp_cycle got %0d want 4", rc); end
        reqWrite = 1'b1;
        reqAddr = 32'h40;
        reqWdata = 32'hCAFEF00D;
        reqValid = 1'b1;
        tick();
        rst = 1'b1;
        reqValid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busA.resp_valid !== 1'b0) badValid++;
            if (busA.req_ready !== 1'b1) badReady++;
            tick();
        end
        checks++; if (badValid !== 0) begin errors++; $display("FAIL t6_no_resp_pulse got %0d pulses want 0", badValid); end
        checks++; if (badReady !== 0) begin errors++; $display("FAIL t6_idle_after_reset got %0d not-ready cycles want 0", badReady); end
        transact(1'b0, 32'h40, 32'h0, rd, e, sc, rc);
        checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL t6_load_after_abort got %h want 11111111", rd); end
    endtask

    initial begin
        test_reset();
        test_store_timing();
        test_back_to_back();
        test_latency_one();
        test_misaligned();
        test_alias();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the memory end of the pipeline's load/store interface.
- Accepts one load or store request from the MEM stage and returns read data after a fixed latency.
- While a request is outstanding it drives a stall back to the pipeline, replacing the single-cycle data RAM with a realistic slow memory.

Parameters:
- ADDR_W, 10, word-address width; storage is 2**ADDR_W 32-bit words.
- LATENCY, 3, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  MEM stage holds a load/store; held stable while stall=1.
- req_write  input  1  1 = store, 0 = load; qualified by req_valid.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept a request this cycle.
- stall  output  1  pipeline must freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- resp_valid  output  1  one-cycle pulse: request complete.
- resp_rdata  output  32  load data; registered, holds until the next response.
- resp_err  output  1  misaligned access flag, qualified by resp_valid.

Behaviour:
- Reset, when rst=1 at an edge:
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Storage contents are not cleared.
  - rst takes priority over any simultaneous request.
- FSM states:
  - IDLE: waiting for a request.
  - WAIT: counting down latency.
  - RESP: response cycle.
- req_ready=1 only in IDLE. A request is accepted on an edge where state=IDLE and req_valid=1.
- The accept edge latches req_write, word index = req_addr[ADDR_W+1:2], req_wdata, and misaligned = (req_addr[1:0]!=0).
- Transitions:
  - IDLE→RESP if LATENCY=1.
  - IDLE→WAIT otherwise, with counter=LATENCY-2.
  - WAIT: counter decrements each cycle; WAIT→RESP when counter=0.
  - RESP→IDLE unconditionally.
- Latency: if the request is accepted at the end of cycle c, resp_valid=1 during cycle c+LATENCY only. The next acceptance is possible at the end of cycle c+LATENCY+1.
- stall = req_valid & (state!=RESP), combinational:
  - In IDLE with a pending request, stall=1 in the accepting cycle.
  - In RESP, stall=0 so the pipeline advances.
  - Because req_ready=0 in RESP, the same request is not re-accepted.
- resp_valid, resp_err and resp_rdata are registered outputs, asserted in RESP.
- The edge entering RESP loads resp_rdata:
  - load: resp_rdata = mem[word index].
  - store: resp_rdata = 0.
- Store commit: mem[word index] is written on the edge leaving RESP. A load issued immediately after a store to the same word returns the new data.
- Address wrap: bits above ADDR_W+1 are ignored, so addresses alias modulo 2**(ADDR_W+2) bytes.
- Misaligned access (addr[1:0]!=0):
  - It is still accepted and timed normally; resp_err=1.
  - A misaligned store is suppressed (memory unchanged).
  - A misaligned load returns resp_rdata=0.
- Reset mid-operation (in WAIT or RESP): return to IDLE with no memory write and no resp_valid pulse.
- Changes to req_* inputs while in WAIT/RESP are ignored; only the latched copies are used.
- req_valid=0 in IDLE: stall=0, state stays IDLE.

Test Plan:
1. Reset, then LATENCY=3: store addr=0x10, wdata=0xDEADBEEF accepted at end of cycle 1 → stall=1 in cycles 1-3, resp_valid=1 in cycle 4 only, resp_err=0, req_ready=0 in cycles 2-4.
2. Store 0x12345678 to 0x20, then load 0x20 back-to-back → load response carries resp_rdata=0x12345678; stall drops exactly in each RESP cycle.
3. LATENCY=1: load from 0x0 after storing 0xA5A5A5A5 → resp_valid the cycle after acceptance with 0xA5A5A5A5; requests are accepted every 2 cycles.
4. Misaligned store to 0x22 of 0xFFFFFFFF, then load 0x20 (previously 0x12345678) → store response has resp_err=1; load returns 0x12345678 with resp_err=0. A misaligned load at 0x21 → resp_rdata=0, resp_err=1.
5. Aliasing with ADDR_W=10: store 0x77 to 0x1000, then load 0x0 → 0x77.
6. Assert rst during WAIT of a store of 0xCAFEF00D to 0x40 (0x40 previously 0x11111111) → no resp_valid pulse, state=IDLE; a subsequent load of 0x40 returns 0x11111111.
